// File: rtl/inst_prefetch_pkg.sv
// rtl/inst_prefetch_pkg.sv - shared bus widths and fetch constants for the instruction prefetcher
package inst_prefetch_pkg;
    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;
    localparam int PC_STEP         = 4;
endpackage

// File: rtl/inst_prefetch_if.sv
// rtl/inst_prefetch_if.sv - ROM read port and consumer handshake of the instruction prefetcher
interface inst_prefetch_if
    import inst_prefetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS_W,
    parameter int INST_W = INST_BUS_W
);
    logic              ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_data_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;
    logic              valid_o;
    logic              ready_i;

    modport master (
        output ce_o, rom_addr_o, inst_o, pc_o, valid_o,
        input  rom_data_i, ready_i
    );

    modport slave (
        input  ce_o, rom_addr_o, inst_o, pc_o, valid_o,
        output rom_data_i, ready_i
    );
endinterface

// File: rtl/inst_prefetch_fetch_fifo.sv
// rtl/inst_prefetch_fetch_fifo.sv - circular queue of {pc, inst} pairs with flush
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Flush only moves pointers; stale storage is unreachable once count is 0.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[tail_q] <= wdata;
    end

    assign rdata = mem_q[head_q];
    assign count = count_q;
endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - sequential instruction fetcher feeding a small prefetch queue
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS_W,
    parameter int                INST_W   = INST_BUS_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    inst_prefetch_if.master   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic                     ce_q, ce_d;
    logic [CNT_W-1:0]         count;
    logic                     push, pop, full;
    logic [ADDR_W+INST_W-1:0] head_entry;

    // A full queue blocks the fetch even when the head leaves this cycle.
    assign full = (count == CNT_W'(DEPTH));
    assign push = ce_q & ~redirect_i & ~full;
    assign pop  = bus.valid_o & bus.ready_i & ~redirect_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ce_d       = 1'b1;
        if (redirect_i)
            fetch_pc_d = redirect_pc_i & WORD_MASK;
        else if (push)
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & WORD_MASK;
            ce_q       <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ce_q       <= ce_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_i),
        .push  (push),
        .pop   (pop),
        .wdata ({fetch_pc_q, bus.rom_data_i}),
        .rdata (head_entry),
        .count (count)
    );

    assign bus.ce_o       = ce_q;
    assign bus.rom_addr_o = fetch_pc_q;
    assign bus.valid_o    = (count != '0);
    assign bus.pc_o       = head_entry[ADDR_W+INST_W-1:INST_W];
    assign bus.inst_o     = head_entry[INST_W-1:0];
endmodule

// File: tb/tb_inst_prefetch.sv
// tb/tb_inst_prefetch.sv - directed and randomized checks of inst_prefetch against a queue model
module tb_inst_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] salt;
    int          checks = 0;
    int          errors = 0;

    logic [63:0] mq[$];
    logic [31:0] m_fpc;
    logic        m_ce;

    always #5 clk = ~clk;

    inst_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus ();
    inst_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus2 ();

    assign bus.rom_data_i  = bus.rom_addr_o ^ salt;
    assign bus.ready_i     = ready;
    assign bus2.rom_data_i = bus2.rom_addr_o;
    assign bus2.ready_i    = 1'b1;

    inst_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .bus           (bus)
    );

    inst_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk           (clk),
        .rst           (rst2),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .bus           (bus2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = 32'h0;
        m_ce  = 1'b0;
    endtask

    task automatic compare_model();
        check("model_ce", bus.ce_o, m_ce);
        check("model_rom_addr", bus.rom_addr_o, m_fpc);
        check("model_valid", bus.valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            check("model_pc", bus.pc_o, mq[0][63:32]);
            check("model_inst", bus.inst_o, mq[0][31:0]);
        end
    endtask

    // One clock: check outputs against the model, then advance the model by the same edge.
    task automatic step();
        logic        do_push, do_pop;
        logic [63:0] entry;
        compare_model();
        do_push = !rst && !redirect && m_ce && (mq.size() < DEPTH);
        do_pop  = !rst && !redirect && (mq.size() != 0) && ready;
        entry   = {m_fpc, m_fpc ^ salt};
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (redirect) begin
            mq.delete();
            m_fpc = redirect_pc & 32'hFFFF_FFFC;
            m_ce  = 1'b1;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(entry);
                m_fpc = m_fpc + 32'd4;
            end
            m_ce = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b0; salt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check("rst_ce", bus.ce_o, 1'b0);
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_rom_addr", bus.rom_addr_o, 32'h0);

        rst = 1'b0; rst2 = 1'b0; ready = 1'b1;
        step();
        check("ce_first_edge", bus.ce_o, 1'b1);
        check("valid_before_push", bus.valid_o, 1'b0);
        check("wrap_valid_before_push", bus2.valid_o, 1'b0);
        step();
        check("first_valid", bus.valid_o, 1'b1);
        check("first_pc", bus.pc_o, 32'h0);
        check("wrap_pc0", bus2.pc_o, 32'hFFFF_FFF8);
        step();
        check("stream_pc4", bus.pc_o, 32'h4);
        check("wrap_pc1", bus2.pc_o, 32'hFFFF_FFFC);
        step();
        check("stream_pc8", bus.pc_o, 32'h8);
        check("wrap_pc2", bus2.pc_o, 32'h0);
        check("wrap_inst2", bus2.inst_o, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stream_pc", bus.pc_o, 32'(12 + 4 * i));
            check("stream_inst", bus.inst_o, 32'(12 + 4 * i));
        end

        rst = 1'b1; ready = 1'b0;
        step();
        rst = 1'b0;
        repeat (8) step();
        check("bp_fetch_hold", bus.rom_addr_o, 32'h10);
        check("bp_ce", bus.ce_o, 1'b1);
        check("bp_head", bus.pc_o, 32'h0);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_pc", bus.pc_o, 32'(4 * i));
            step();
        end

        rst = 1'b1; ready = 1'b0;
        step();
        rst = 1'b0;
        repeat (4) step();
        check("redir_pre_fetch", bus.rom_addr_o, 32'hC);
        ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
        check("redir_pre_head", bus.pc_o, 32'h0);
        step();
        redirect = 1'b0;
        check("redir_valid", bus.valid_o, 1'b0);
        check("redir_rom_addr", bus.rom_addr_o, 32'h100);
        step();
        check("redir_pc0", bus.pc_o, 32'h100);
        step();
        check("redir_pc1", bus.pc_o, 32'h104);

        rst = 1'b1;
        step();
        rst = 1'b0; ready = 1'b0;
        repeat (3) step();
        check("mid_pre_fetch", bus.rom_addr_o, 32'h8);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        check("mid_valid", bus.valid_o, 1'b0);
        check("mid_rom_addr", bus.rom_addr_o, 32'h0);
        check("mid_ce", bus.ce_o, 1'b0);
        rst = 1'b0; redirect = 1'b0;

        salt = $urandom;
        for (int i = 0; i < 3000; i++) begin
            ready       = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 31) == 0);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; redirect = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction address width (matches `InstAddrBus`).
REQ-002 SHALL have parameter INST_W, default 32, instruction word width (matches `InstBus`).
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ce_o  output  1  instruction ROM chip enable.
REQ-008 SHALL have port rom_addr_o  output  ADDR_W  ROM read address (combinational-read ROM).
REQ-009 SHALL have port rom_data_i  input  INST_W  ROM read data, valid in the same cycle as rom_addr_o.
REQ-010 SHALL have port redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc_i  input  ADDR_W  redirect target.
REQ-012 SHALL have port inst_o  output  INST_W  head-of-queue instruction.
REQ-013 SHALL have port pc_o  output  ADDR_W  address of inst_o.
REQ-014 SHALL have port valid_o  output  1  queue non-empty.
REQ-015 SHALL have port ready_i  input  1  consumer accepts head this cycle.

Function
REQ-016 SHALL keep registered fetch_pc, registered ce_o, and a DEPTH-entry FIFO of {pc, inst} pairs with count of width clog2(DEPTH)+1.
REQ-017 SHALL drive rom_addr_o = fetch_pc at all times; fetch_pc low 2 bits always 0.
REQ-018 SHALL define push = ce_o & ~redirect_i & (count < DEPTH); push writes {fetch_pc, rom_data_i} at tail and sets fetch_pc <= fetch_pc + 4 (mod 2^ADDR_W, wrap silently).
REQ-019 SHALL define pop = valid_o & ready_i & ~redirect_i; pop advances head.
REQ-020 SHALL not let ready_i gate push combinationally: when count == DEPTH, push = 0 even if pop = 1.
REQ-021 SHALL update count as count + push - pop; push and pop in the same cycle leave count unchanged.
REQ-022 SHALL, on redirect_i = 1, clear the FIFO (count <= 0, head = tail), set fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}, and suppress push and pop that cycle; redirect overrides every other event.
REQ-023 SHALL present inst_o/pc_o from the head entry combinationally; values are don't-care when valid_o = 0.
REQ-024 SHALL make valid_o = (count != 0); the first instruction appears on valid_o one cycle after its push.
REQ-025 SHALL keep head/tail pointers of width clog2(DEPTH), wrapping naturally from DEPTH-1 to 0.
REQ-026 SHALL hold fetch_pc when count == DEPTH (back-pressure), and hold the FIFO when ready_i = 0.

Reset
REQ-027 SHALL, while rst = 1 at a clock edge, set fetch_pc <= RESET_PC, ce_o <= 0, count/head/tail <= 0; rst takes priority over redirect_i.
REQ-028 SHALL set ce_o <= 1 on the first edge with rst = 0; fetching begins in the cycle after that edge.
REQ-029 SHALL, on reset asserted mid-operation, discard all queued entries; valid_o = 0 from the next cycle.

Structure
REQ-030 SHALL take bus widths from the shared defines header (`InstBus`, `InstAddrBus`) as parameter defaults; no new package types required.
REQ-031 SHALL implement the queue as one sub-module, fetch_fifo (parameters WIDTH = ADDR_W+INST_W, DEPTH; ports clk, rst, flush, push, pop, wdata, rdata, count).
REQ-032 SHALL keep the PC/ce logic in inst_prefetch; total RTL 120-400 lines.

Verification
REQ-033 SHALL check reset: rst 1 for 2 cycles, then 0 -> ce_o = 0 during reset, 1 after first edge; first entry pc_o = 0x0, valid_o rises one cycle after first push.
REQ-034 SHALL check streaming: ready_i = 1 constantly, ROM returns addr -> pc_o sequence 0x0, 0x4, 0x8, ... one per cycle, inst_o == pc_o.
REQ-035 SHALL check back-pressure: ready_i = 0 -> count saturates at 4, fetch_pc holds 0x10, ce_o stays 1, no entry overwritten; release ready_i -> 0x0..0xC drain in order.
REQ-036 SHALL check redirect: redirect_i = 1, redirect_pc_i = 0x103 while count = 3, ready_i = 1 -> next cycle valid_o = 0, no pop that cycle, rom_addr_o = 0x100; following output pc_o = 0x100, 0x104.
REQ-037 SHALL check wrap: fetch from RESET_PC = 0xFFFFFFF8 -> pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-038 SHALL check reset mid-stream: rst = 1 with count = 2 and redirect_i = 1 -> count = 0, fetch_pc = RESET_PC (not redirect target).
